// File: rtl/reg_debug_port_pkg.sv
// Shared constants and state encoding for the register-file debug port.
// Imported by the interface, the debug-port FSM and anything driving it.
package reg_debug_port_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 8;
   localparam int REG_CNT_W  = 5;
   localparam int NUM_REGS   = 16;

   localparam logic CMD_DUMP = 1'b0;
   localparam logic CMD_LOAD = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DUMP_FETCH = 3'd1,
      ST_DUMP_SEND  = 3'd2,
      ST_LOAD       = 3'd3,
      ST_DONE       = 3'd4
   } state_e;

endpackage

// File: rtl/reg_debug_port_if.sv
// Command, register-file and byte-stream signals of the debug port.
// The master modport is the debug port itself; slave is the surrounding system.
interface reg_debug_port_if
   import reg_debug_port_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W,
   parameter int CNT_W  = REG_CNT_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_load;
   logic [ADDR_W-1:0] cmd_first;
   logic [CNT_W-1:0]  cmd_count;

   logic [ADDR_W-1:0] rf_ra;
   logic [DATA_W-1:0] rf_rd;
   logic [ADDR_W-1:0] rf_wa;
   logic [DATA_W-1:0] rf_wd;
   logic              rf_we;

   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   logic              busy;
   logic              done;

   modport master (
      input  cmd_valid, cmd_load, cmd_first, cmd_count, rf_rd, out_ready, in_valid, in_data,
      output cmd_ready, rf_ra, rf_wa, rf_wd, rf_we, out_valid, out_data, out_last, in_ready,
             busy, done
   );

   modport slave (
      output cmd_valid, cmd_load, cmd_first, cmd_count, rf_rd, out_ready, in_valid, in_data,
      input  cmd_ready, rf_ra, rf_wa, rf_wd, rf_we, out_valid, out_data, out_last, in_ready,
             busy, done
   );

endinterface

// File: rtl/reg_debug_port.sv
// Debug initiator for the 16x8 register file: dumps a register range to a byte
// stream or loads a range from one, owning the rf_* port while busy.
module reg_debug_port
   import reg_debug_port_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W,
   parameter int CNT_W  = REG_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   reg_debug_port_if.master  bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic [CNT_W-1:0]  count_clamped;

   // Requests beyond the register file size dump or load the whole file once.
   assign count_clamped = (bus.cmd_count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : bus.cmd_count;

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               addr_d      = bus.cmd_first;
               remaining_d = count_clamped;
               if (count_clamped == '0)
                  state_d = ST_DONE;
               else if (bus.cmd_load == CMD_LOAD)
                  state_d = ST_LOAD;
               else
                  state_d = ST_DUMP_FETCH;
            end
         end
         ST_DUMP_FETCH: begin
            out_data_d  = bus.rf_rd;
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == CNT_W'(1));
            state_d     = ST_DUMP_SEND;
         end
         ST_DUMP_SEND: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               remaining_d = remaining_q - CNT_W'(1);
               addr_d      = addr_q + ADDR_W'(1);
               state_d     = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_DUMP_FETCH;
            end
         end
         ST_LOAD: begin
            if (bus.in_valid) begin
               remaining_d = remaining_q - CNT_W'(1);
               addr_d      = addr_q + ADDR_W'(1);
               if (remaining_q == CNT_W'(1))
                  state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE);

   assign bus.rf_ra     = addr_q;
   assign bus.rf_wa     = addr_q;
   assign bus.rf_wd     = bus.in_data;
   // A reset landing mid-load must not let the abandoned command write once more.
   assign bus.rf_we     = bus.in_valid & (state_q == ST_LOAD) & ~rst;
   assign bus.in_ready  = (state_q == ST_LOAD);

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_reg_debug_port.sv
// Directed bench for reg_debug_port with a behavioural 16x8 register file on rf_*.
// Each scenario task drives its own stimulus and compares against hand-derived bytes.
module tb_reg_debug_port;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_debug_port_if bus ();
   reg_debug_port dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] rf_mem [16];
   logic [7:0] model  [16];
   logic       pre_we;
   logic [3:0] pre_wa;
   logic [7:0] pre_wd;

   int n_cmp = 0, n_bad = 0;
   int we_cnt = 0, done_cnt = 0, ov_cnt = 0;

   assign bus.rf_rd = rf_mem[bus.rf_ra];

   always @(posedge clk) begin
      if (bus.rf_we)   rf_mem[bus.rf_wa] <= bus.rf_wd;
      else if (pre_we) rf_mem[pre_wa]    <= pre_wd;
   end

   // Event counters let scenarios check pulse counts by taking before/after snapshots.
   always @(posedge clk) begin
      if (bus.rf_we)     we_cnt   <= we_cnt + 1;
      if (bus.done)      done_cnt <= done_cnt + 1;
      if (bus.out_valid) ov_cnt   <= ov_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic load, input logic [3:0] first, input logic [4:0] count);
      bit ok = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = load;
      bus.cmd_first = first;
      bus.cmd_count = count;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = bus.cmd_ready;
      end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL cmd_accept: cmd_ready got 0 want 1 within 20 cycles"); end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_dump(input string name, input int first, input int count, input int stall);
      logic [7:0] exp[$];
      int n, idx, wait_left;
      n = (count > 16) ? 16 : count;
      for (int i = 0; i < n; i++) exp.push_back(model[(first + i) % 16]);
      send_cmd(1'b0, first[3:0], count[4:0]);
      bus.out_ready = (stall == 0);
      idx = 0;
      wait_left = stall;
      for (int c = 0; c < 400 && idx < n; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            n_cmp++;
            if (bus.out_data !== exp[idx]) begin
               n_bad++;
               $display("FAIL %s data[%0d]: got %h want %h", name, idx, bus.out_data, exp[idx]);
            end
            n_cmp++;
            if (bus.out_last !== (idx == n - 1)) begin
               n_bad++;
               $display("FAIL %s last[%0d]: got %b want %b", name, idx, bus.out_last, (idx == n - 1));
            end
            if (bus.out_ready) begin idx++; wait_left = stall; end
            else wait_left--;
         end
         @(posedge clk); #1;
         bus.out_ready = (wait_left <= 0);
      end
      n_cmp++;
      if (idx != n) begin n_bad++; $display("FAIL %s byte_count: got %0d want %0d", name, idx, n); end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s done_after_last: got done=%b valid=%b want done=1 valid=0", name, bus.done, bus.out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s idle_after_done: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({bus.cmd_ready, bus.busy, bus.out_valid, bus.out_last, bus.done, bus.rf_we, bus.in_ready} !== 7'b1000000) begin
         n_bad++;
         $display("FAIL reset_flags: got rdy/busy/ov/last/done/we/ir=%b want 1000000",
                  {bus.cmd_ready, bus.busy, bus.out_valid, bus.out_last, bus.done, bus.rf_we, bus.in_ready});
      end
      n_cmp++;
      if (bus.out_data !== 8'h00 || bus.rf_ra !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_values: got out_data=%h rf_ra=%h want 00 0", bus.out_data, bus.rf_ra);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_load();
      logic [7:0] d [3];
      int we0;
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      we0 = we_cnt;
      send_cmd(1'b1, 4'd5, 5'd3);
      for (int i = 0; i < 3; i++) begin
         bit ok = 1'b0;
         repeat (2) begin @(posedge clk); #1; end
         bus.in_valid = 1'b1;
         bus.in_data  = d[i];
         for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (!ok) begin @(posedge clk); #1; end
         end
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL load in_ready[%0d]: got 0 want 1", i); end
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         model[5 + i] = d[i];
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b1) begin n_bad++; $display("FAIL load done: got %b want 1", bus.done); end
      n_cmp++;
      if (we_cnt - we0 != 3) begin n_bad++; $display("FAIL load we_pulses: got %0d want 3", we_cnt - we0); end
      @(posedge clk); #1;
      run_dump("load_readback", 4, 5, 0);
   endtask

   task automatic test_zero_and_oversize();
      int we0, ov0, d0;
      we0 = we_cnt; ov0 = ov_cnt; d0 = done_cnt;
      send_cmd(1'b0, 4'd4, 5'd0);
      repeat (4) begin @(posedge clk); #1; end
      n_cmp++;
      if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL zero done_pulses: got %0d want 1", done_cnt - d0); end
      n_cmp++;
      if (we_cnt - we0 != 0 || ov_cnt - ov0 != 0) begin
         n_bad++;
         $display("FAIL zero traffic: got we=%0d ov=%0d want 0 0", we_cnt - we0, ov_cnt - ov0);
      end
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL zero idle: got cmd_ready=%b want 1", bus.cmd_ready); end
      ov0 = ov_cnt;
      run_dump("count31", 0, 31, 0);
      n_cmp++;
      if (ov_cnt - ov0 != 16) begin n_bad++; $display("FAIL count31 valid_cycles: got %0d want 16", ov_cnt - ov0); end
   endtask

   task automatic test_reset_mid_load();
      int we0, d0;
      we0 = we_cnt; d0 = done_cnt;
      send_cmd(1'b1, 4'd8, 5'd6);
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h51 + 8'(i);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL abort idle: got rdy=%b ov=%b ir=%b want 1 0 0", bus.cmd_ready, bus.out_valid, bus.in_ready);
      end
      // Bytes offered while idle must not reach the register file.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h53;
      repeat (3) begin @(posedge clk); #1; end
      bus.in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (we_cnt - we0 != 2) begin n_bad++; $display("FAIL abort we_pulses: got %0d want 2", we_cnt - we0); end
      n_cmp++;
      if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL abort done_pulses: got %0d want 0", done_cnt - d0); end
      n_cmp++;
      if (rf_mem[8] !== 8'h51 || rf_mem[9] !== 8'h52 || rf_mem[10] !== 8'hAA) begin
         n_bad++;
         $display("FAIL abort regs: got %h %h %h want 51 52 aa", rf_mem[8], rf_mem[9], rf_mem[10]);
      end
      model[8] = 8'h51;
      model[9] = 8'h52;
      run_dump("abort_readback", 8, 4, 0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_load  = 1'b0;
      bus.cmd_first = '0;
      bus.cmd_count = '0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      for (int i = 0; i < 16; i++) begin
         pre_we   = 1'b1;
         pre_wa   = 4'(i);
         pre_wd   = 8'hA0 + 8'(i);
         model[i] = 8'hA0 + 8'(i);
         @(posedge clk); #1;
      end
      pre_we = 1'b0;

      test_reset();
      run_dump("dump_full", 0, 16, 0);
      run_dump("dump_wrap", 14, 4, 0);
      run_dump("dump_stall", 3, 2, 5);
      test_load();
      test_zero_and_oversize();
      test_reset_mid_load();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
